// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared widths and tags for the per-thread register-file write-back controller.
package regfile_wb_ctrl_pkg;
  localparam int DATA_BITS      = 8;
  localparam int ADDR_BITS      = 4;
  localparam int FIRST_RO_REG   = 13;
  localparam int NUM_REGS       = 16;
  localparam int LSU_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_EXEC = 2'd1,
    WB_LSU  = 2'd2
  } wb_source_e;
endpackage

// File: rtl/regfile_wb_ctrl_wb_fifo.sv
// Small synchronous FIFO buffering LSU load returns until the write port is free.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   CNT_MAX = DEPTH;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [PW:0]                 count;
  logic                        do_push, do_pop;

  assign full     = (count == CNT_MAX);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Per-thread write-back arbiter (exec over LSU) with a load-destination hazard scoreboard.
module regfile_wb_ctrl #(
  parameter int DATA_BITS      = regfile_wb_ctrl_pkg::DATA_BITS,
  parameter int ADDR_BITS      = regfile_wb_ctrl_pkg::ADDR_BITS,
  parameter int FIRST_RO_REG   = regfile_wb_ctrl_pkg::FIRST_RO_REG,
  parameter int LSU_FIFO_DEPTH = regfile_wb_ctrl_pkg::LSU_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [ADDR_BITS-1:0] issue_rs_address,
  input  logic [ADDR_BITS-1:0] issue_rt_address,
  input  logic [ADDR_BITS-1:0] issue_rd_address,
  input  logic                 issue_is_load,
  output logic                 issue_stall,
  input  logic                 exec_wr_valid,
  input  logic [ADDR_BITS-1:0] exec_wr_address,
  input  logic [DATA_BITS-1:0] exec_wr_data,
  input  logic                 lsu_wr_valid,
  output logic                 lsu_wr_ready,
  input  logic [ADDR_BITS-1:0] lsu_wr_address,
  input  logic [DATA_BITS-1:0] lsu_wr_data,
  output logic                 reg_write_enable,
  output logic [ADDR_BITS-1:0] reg_rd_address,
  output logic [DATA_BITS-1:0] reg_rd_data,
  output logic                 ro_write_drop,
  output logic [ADDR_BITS:0]   pending_loads,
  output logic                 idle
);
  import regfile_wb_ctrl_pkg::*;

  localparam int NREGS = 2**ADDR_BITS;
  localparam int EW    = ADDR_BITS + DATA_BITS;
  localparam logic [ADDR_BITS-1:0] RO_BASE = ADDR_BITS'(FIRST_RO_REG);

  logic [NREGS-1:0]     sb, sb_next;
  logic                 fifo_full, fifo_empty, push, pop, set_load;
  logic [EW-1:0]        head;
  wb_source_e           sel_src;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_valid, sel_ro;

  assign lsu_wr_ready = ~fifo_full;
  assign push         = lsu_wr_valid & ~fifo_full;
  assign pop          = ~exec_wr_valid & ~fifo_empty;
  assign issue_stall  = issue_valid &
                        (sb[issue_rs_address] | sb[issue_rt_address] | sb[issue_rd_address]);
  assign set_load     = issue_valid & ~issue_stall & issue_is_load & (issue_rd_address < RO_BASE);

  wb_fifo #(.DEPTH(LSU_FIFO_DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({lsu_wr_address, lsu_wr_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Exec path cannot stall, so it always wins; LSU drains only in exec bubbles.
  always_comb begin
    sel_src  = WB_NONE;
    sel_addr = '0;
    sel_data = '0;
    if (exec_wr_valid) begin
      sel_src  = WB_EXEC;
      sel_addr = exec_wr_address;
      sel_data = exec_wr_data;
    end else if (!fifo_empty) begin
      sel_src  = WB_LSU;
      {sel_addr, sel_data} = head;
    end
  end

  assign sel_valid = (sel_src != WB_NONE);
  assign sel_ro    = (sel_addr >= RO_BASE);

  // Clear first, then set, so a coincident set on the same bit wins.
  always_comb begin
    sb_next = sb;
    if (reg_write_enable) sb_next[reg_rd_address] = 1'b0;
    if (set_load)         sb_next[issue_rd_address] = 1'b1;
  end

  always_comb begin
    pending_loads = '0;
    for (int i = 0; i < NREGS; i++) pending_loads = pending_loads + (ADDR_BITS+1)'(sb[i]);
  end

  assign idle = fifo_empty & ~|sb & ~reg_write_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_enable <= 1'b0;
      reg_rd_address   <= '0;
      reg_rd_data      <= '0;
      ro_write_drop    <= 1'b0;
      sb               <= '0;
    end else begin
      reg_write_enable <= sel_valid & ~sel_ro;
      ro_write_drop    <= sel_valid & sel_ro;
      if (sel_valid) begin
        reg_rd_address <= sel_addr;
        reg_rd_data    <= sel_data;
      end
      sb <= sb_next;
    end
  end
endmodule
